// File: rtl/or_pkg.sv
// rtl/or_pkg.sv - shared mode type and tree-geometry helpers for or_nway_pipe
package or_pkg;

  typedef enum logic [1:0] {OR_M, NOR_M, ACC_M, ACC_LOAD_M} or_mode_t;

  function automatic int or_levels(input int w);
    return $clog2(w);
  endfunction

  // bits held at tree level k (level 0 is the input word)
  function automatic int lvl_width(input int w, input int k);
    return (w + (1 << k) - 1) >> k;
  endfunction

  // bit offset of level k inside the flattened level bus
  function automatic int lvl_offset(input int w, input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += lvl_width(w, j);
    return s;
  endfunction

endpackage

// File: rtl/or_pipe_stage.sv
// rtl/or_pipe_stage.sv - one registered level of the OR reduction tree
module or_pipe_stage #(
  parameter  int IN_W  = 2,
  localparam int OUT_W = (IN_W + 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [IN_W-1:0]  up_data,
  input  logic [1:0]       up_mode,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [OUT_W-1:0] dn_data,
  output logic [1:0]       dn_mode,
  output logic [OUT_W-1:0] red,
  input  logic [OUT_W-1:0] ld_data
);

  // zero padding is the OR identity, so odd widths need no special case
  logic [2*OUT_W-1:0] padded;
  assign padded = (2*OUT_W)'(up_data);

  always_comb begin
    red = '0;
    for (int i = 0; i < OUT_W; i++) red[i] = padded[2*i] | padded[2*i+1];
  end

  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_mode  <= 2'b00;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data <= ld_data;
        dn_mode <= up_mode;
      end
    end
  end

endmodule

// File: rtl/or_nway_pipe.sv
// rtl/or_nway_pipe.sv - pipelined N-way OR/NOR/accumulate reduction with valid/ready
module or_nway_pipe
  import or_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit
);

  localparam int LAT = or_levels(WIDTH);
  localparam int TOT = lvl_offset(WIDTH, LAT + 1);

  logic [TOT-1:0]       data_bus;
  logic [LAT:0]         vld;
  logic [LAT+1:1]       rdy;
  logic [LAT:0][1:0]    mode_bus;
  logic                 r_bit;
  logic                 fin_bit;
  logic                 fin_load;
  logic                 acc;
  logic                 acc_d;
  logic [1:0]           unused_last_mode;

  assign data_bus[WIDTH-1:0] = in_data;
  assign vld[0]              = in_valid;
  assign mode_bus[0]         = in_mode;
  assign rdy[LAT+1]          = out_ready;
  assign in_ready            = rdy[1];
  assign out_valid           = vld[LAT];
  assign out_bit             = data_bus[TOT-1];
  assign unused_last_mode    = mode_bus[LAT];

  for (genvar k = 1; k <= LAT; k++) begin : g_lvl
    localparam int IW   = lvl_width(WIDTH, k - 1);
    localparam int OW   = lvl_width(WIDTH, k);
    localparam int OFFI = lvl_offset(WIDTH, k - 1);
    localparam int OFFO = lvl_offset(WIDTH, k);

    logic [OW-1:0] red;
    logic [OW-1:0] ld;

    // the final level stores the mode-applied result instead of the raw OR
    if (k == LAT) begin : g_last
      assign r_bit = red[0];
      assign ld    = fin_bit;
    end else begin : g_mid
      assign ld = red;
    end

    or_pipe_stage #(.IN_W(IW)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (vld[k-1]),
      .up_ready (rdy[k]),
      .up_data  (data_bus[OFFI +: IW]),
      .up_mode  (mode_bus[k-1]),
      .dn_valid (vld[k]),
      .dn_ready (rdy[k+1]),
      .dn_data  (data_bus[OFFO +: OW]),
      .dn_mode  (mode_bus[k]),
      .red      (red),
      .ld_data  (ld)
    );
  end

  assign fin_load = vld[LAT-1] && rdy[LAT];

  always_comb begin
    fin_bit = r_bit;
    acc_d   = acc;
    case (or_mode_t'(mode_bus[LAT-1]))
      OR_M:       fin_bit = r_bit;
      NOR_M:      fin_bit = ~r_bit;
      ACC_M: begin
        fin_bit = acc | r_bit;
        acc_d   = acc | r_bit;
      end
      ACC_LOAD_M: acc_d = r_bit;
      default:    fin_bit = r_bit;
    endcase
  end

  // acc moves only when a word lands in the final register, so stalls cannot skew it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= 1'b0;
    else if (fin_load) acc <= acc_d;
  end

endmodule

// File: tb/tb_or_nway_pipe.sv
// tb/tb_or_nway_pipe.sv - directed self-checking bench for or_nway_pipe at WIDTH 2, 16 and 5
module tb_or_nway_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_iv = 0, a_ir, a_ov, a_or = 1, a_ob;
  logic [1:0] a_id = '0, a_im = '0;
  logic b_iv = 0, b_ir, b_ov, b_or = 1, b_ob;
  logic [15:0] b_id = '0;
  logic [1:0] b_im = '0;
  logic c_iv = 0, c_ir, c_ov, c_or = 1, c_ob;
  logic [4:0] c_id = '0;
  logic [1:0] c_im = '0;

  or_nway_pipe #(.WIDTH(2)) u_a (.clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_mode(a_im), .out_valid(a_ov), .out_ready(a_or), .out_bit(a_ob));
  or_nway_pipe #(.WIDTH(16)) u_b (.clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_mode(b_im), .out_valid(b_ov), .out_ready(b_or), .out_bit(b_ob));
  or_nway_pipe #(.WIDTH(5)) u_c (.clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .in_data(c_id), .in_mode(c_im), .out_valid(c_ov), .out_ready(c_or), .out_bit(c_ob));

  int a_ac[$], a_oc[$], b_ac[$], b_oc[$], c_ac[$], c_oc[$];
  logic a_bq[$], b_bq[$], c_bq[$];

  always @(negedge clk) begin
    if (a_iv && a_ir) a_ac.push_back(cyc);
    if (a_ov && a_or) begin a_bq.push_back(a_ob); a_oc.push_back(cyc); end
    if (b_iv && b_ir) b_ac.push_back(cyc);
    if (b_ov && b_or) begin b_bq.push_back(b_ob); b_oc.push_back(cyc); end
    if (c_iv && c_ir) c_ac.push_back(cyc);
    if (c_ov && c_or) begin c_bq.push_back(c_ob); c_oc.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // each put starts just after a rising edge and returns just after its accepting edge
  task automatic put_a(input logic [1:0] d, input logic [1:0] m);
    int k = 0;
    a_iv = 1; a_id = d; a_im = m;
    @(negedge clk);
    while (!a_ir && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("a_put_timeout", 0, 1);
    @(posedge clk); #1 a_iv = 0;
  endtask

  task automatic put_b(input logic [15:0] d, input logic [1:0] m);
    int k = 0;
    b_iv = 1; b_id = d; b_im = m;
    @(negedge clk);
    while (!b_ir && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("b_put_timeout", 0, 1);
    @(posedge clk); #1 b_iv = 0;
  endtask

  task automatic put_c(input logic [4:0] d, input logic [1:0] m);
    int k = 0;
    c_iv = 1; c_id = d; c_im = m;
    @(negedge clk);
    while (!c_ir && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("c_put_timeout", 0, 1);
    @(posedge clk); #1 c_iv = 0;
  endtask

  task automatic wait_out(input int which, input int n);
    int k = 0;
    int sz;
    sz = (which == 0) ? a_bq.size() : (which == 1) ? b_bq.size() : c_bq.size();
    while (sz < n && k < 50) begin
      @(negedge clk);
      k++;
      sz = (which == 0) ? a_bq.size() : (which == 1) ? b_bq.size() : c_bq.size();
    end
    check("drain_count", sz, n);
    @(posedge clk); #1;
  endtask

  logic exp1 [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  logic exp3 [6] = '{1, 0, 0, 1, 0, 1};
  logic [15:0] w3 [6] = '{16'h0010, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0002};
  logic [1:0]  m4 [7] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd3};
  logic [15:0] d4 [7] = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic exp4 [7] = '{0, 0, 1, 1, 0, 1, 0};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_out_valid", a_ov, 0);
    check("rst_b_out_valid", b_ov, 0);
    check("rst_b_out_bit", b_ob, 0);
    check("rst_b_in_ready", b_ir, 1);
    check("rst_c_in_ready", c_ir, 1);
    rst_n = 1;
    @(posedge clk); #1;

    // WIDTH=2 truth table, OR then NOR
    for (int i = 0; i < 4; i++) put_a(2'(i), 2'd0);
    for (int i = 0; i < 4; i++) put_a(2'(i), 2'd1);
    wait_out(0, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("w2_bit%0d", i), a_bq[i], exp1[i]);
      check($sformatf("w2_lat%0d", i), a_oc[i] - a_ac[i], 1);
    end

    // WIDTH=16 back-to-back throughput
    put_b(16'h0000, 2'd0);
    put_b(16'h8000, 2'd0);
    put_b(16'h0001, 2'd0);
    put_b(16'h0000, 2'd0);
    wait_out(1, 4);
    check("thr_b0", b_bq[0], 0);
    check("thr_b1", b_bq[1], 1);
    check("thr_b2", b_bq[2], 1);
    check("thr_b3", b_bq[3], 0);
    for (int i = 0; i < 4; i++) check($sformatf("thr_lat%0d", i), b_oc[i] - b_ac[i], 4);
    for (int i = 1; i < 4; i++) check($sformatf("thr_gap%0d", i), b_ac[i] - b_ac[i-1], 1);

    // backpressure: fill 4 levels, stall 3 cycles, then deliver all 6
    b_bq.delete(); b_oc.delete(); b_ac.delete();
    b_or = 0;
    for (int i = 0; i < 4; i++) put_b(w3[i], 2'd0);
    b_iv = 1; b_id = w3[4]; b_im = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready%0d", i), b_ir, 0);
      check($sformatf("stall_out_valid%0d", i), b_ov, 1);
      check($sformatf("stall_out_bit%0d", i), b_ob, 1);
    end
    @(posedge clk); #1 b_or = 1;
    put_b(w3[4], 2'd0);
    put_b(w3[5], 2'd0);
    wait_out(1, 6);
    repeat (4) @(posedge clk);
    #1 check("bp_count", b_bq.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("bp_bit%0d", i), b_bq[i], exp3[i]);

    // accumulator sequence
    b_bq.delete(); b_oc.delete(); b_ac.delete();
    for (int i = 0; i < 7; i++) put_b(d4[i], m4[i]);
    wait_out(1, 7);
    for (int i = 0; i < 7; i++) check($sformatf("acc_bit%0d", i), b_bq[i], exp4[i]);

    // odd width, WIDTH=5
    put_c(5'b10000, 2'd0);
    put_c(5'b00000, 2'd0);
    put_c(5'b00001, 2'd0);
    wait_out(2, 3);
    check("w5_bit0", c_bq[0], 1);
    check("w5_bit1", c_bq[1], 0);
    check("w5_bit2", c_bq[2], 1);
    for (int i = 0; i < 3; i++) check($sformatf("w5_lat%0d", i), c_oc[i] - c_ac[i], 3);

    // reset mid-operation with acc=1 and a full pipeline
    b_bq.delete(); b_oc.delete(); b_ac.delete();
    put_b(16'h0001, 2'd3);
    wait_out(1, 1);
    check("pre_rst_load", b_bq[0], 1);
    b_or = 0;
    for (int i = 0; i < 4; i++) put_b(16'h0000, 2'd2);
    check("pre_rst_out_bit", b_ob, 1);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", b_ov, 0);
    check("mid_rst_out_bit", b_ob, 0);
    check("mid_rst_in_ready", b_ir, 1);
    b_or = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("mid_rst_no_output", b_bq.size(), 1);
    put_b(16'h0000, 2'd2);
    wait_out(1, 2);
    check("post_rst_acc", b_bq[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
